// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with valid/ready on both sides.
// Variable shifts iterate one bit per clock instead of using a barrel shifter.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_kind;
  logic [WIDTH-1:0] r_result;
  logic             r_c;
  logic             r_z;
  logic             r_n;
  logic             r_v;
  logic             r_ill;
  logic             r_out_valid;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [SHW-1:0]   w_amt;
  logic             w_is_sh;
  logic             w_long;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_sh_out;

  assign in_ready = !rst &&
    (r_state == S_IDLE ||
     (r_state == S_DONE && out_ready));

  assign w_accept = in_valid && in_ready;

  assign w_sum = {1'b0, op_a} + {1'b0, op_b};
  assign w_dif = {1'b0, op_a} - {1'b0, op_b};
  assign w_amt = op_b[SHW-1:0];

  assign w_is_sh = (op_sel == 4'd9) ||
                   (op_sel == 4'd10) ||
                   (op_sel == 4'd11);
  assign w_long  = w_is_sh && (w_amt != '0);

  // Single-cycle result and flags for the op on the input port
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    unique case (op_sel)
      4'd0: w_res = '0;
      4'd1: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'd2: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                (w_dif[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'd3: w_res = op_a & op_b;
      4'd4: w_res = op_a | op_b;
      4'd5: w_res = op_a ^ op_b;
      4'd6: w_res = ~op_a;
      4'd7: begin
        w_res = {op_a[WIDTH-2:0], 1'b0};
        w_c   = op_a[WIDTH-1];
      end
      4'd8: begin
        w_res = {1'b0, op_a[WIDTH-1:1]};
        w_c   = op_a[0];
      end
      4'd9, 4'd10, 4'd11: w_res = op_a;
      default: w_ill = 1'b1;
    endcase
  end

  // One-bit step of the iterative shifter
  always_comb begin
    w_sh_nxt = r_sh;
    w_sh_out = 1'b0;
    unique case (r_kind)
      2'd0: begin
        w_sh_nxt = {r_sh[WIDTH-2:0], 1'b0};
        w_sh_out = r_sh[WIDTH-1];
      end
      2'd1: begin
        w_sh_nxt = {1'b0, r_sh[WIDTH-1:1]};
        w_sh_out = r_sh[0];
      end
      default: begin
        w_sh_nxt = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
        w_sh_out = r_sh[0];
      end
    endcase
  end

  // Control FSM with registered result, flags and out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_kind      <= 2'd0;
      r_result    <= '0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
      r_ill       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      if (w_long) begin
        r_state     <= S_SHIFT;
        r_sh        <= op_a;
        r_cnt       <= w_amt;
        r_kind      <= op_sel[1:0] - 2'd1;
        r_ill       <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        r_state     <= S_DONE;
        r_result    <= w_res;
        r_c         <= w_c;
        r_z         <= (w_res == '0);
        r_n         <= w_res[WIDTH-1];
        r_v         <= w_v;
        r_ill       <= w_ill;
        r_out_valid <= 1'b1;
      end
    end else begin
      unique case (r_state)
        S_SHIFT: begin
          r_sh  <= w_sh_nxt;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_state     <= S_DONE;
            r_result    <= w_sh_nxt;
            r_c         <= w_sh_out;
            r_z         <= (w_sh_nxt == '0);
            r_n         <= w_sh_nxt[WIDTH-1];
            r_v         <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag_c    = r_c;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_v    = r_v;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a behavioural model.
// Driver pushes expectations on accept; monitor pops on output transfer.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [3:0]   op_sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         flag_c, flag_z, flag_n, flag_v, illegal;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .flag_c(flag_c), .flag_z(flag_z),
    .flag_n(flag_n), .flag_v(flag_v),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic c, z, n, v, ill;
    int lat;
    time t;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int bp_mode = 0;
  bit seen = 0;

  function automatic exp_t model(logic [7:0] a, logic [7:0] b,
                                 logic [3:0] op);
    exp_t m;
    int ia, ib, sa, sb, sh, full;
    ia = a; ib = b; sa = $signed(a); sb = $signed(b);
    sh = b % 8;
    full = 0;
    m.r = 0; m.c = 0; m.v = 0; m.ill = 0; m.lat = 1; m.t = 0;
    case (op)
      4'd0: m.r = 0;
      4'd1: begin
        full = ia + ib; m.r = full[7:0]; m.c = (full > 255);
        m.v = (sa + sb > 127) || (sa + sb < -128);
      end
      4'd2: begin
        full = ia - ib; m.r = full[7:0]; m.c = (ia < ib);
        m.v = (sa - sb > 127) || (sa - sb < -128);
      end
      4'd3: m.r = a & b;
      4'd4: m.r = a | b;
      4'd5: m.r = a ^ b;
      4'd6: m.r = ~a;
      4'd7: begin
        full = ia * 2; m.r = full[7:0]; m.c = (ia >= 128);
      end
      4'd8: begin m.r = a / 2; m.c = ia % 2; end
      4'd9: begin
        full = ia << sh; m.r = full[7:0];
        m.c = (sh != 0) && (((ia >> (8 - sh)) % 2) == 1);
      end
      4'd10: begin
        full = ia >> sh; m.r = full[7:0];
        m.c = (sh != 0) && (((ia >> (sh - 1)) % 2) == 1);
      end
      4'd11: begin
        full = sa >>> sh; m.r = full[7:0];
        m.c = (sh != 0) && (((ia >> (sh - 1)) % 2) == 1);
      end
      default: m.ill = 1;
    endcase
    if (op >= 9 && op <= 11 && sh != 0) m.lat = sh + 1;
    m.z = (m.r == 0);
    m.n = m.r[7];
    return m;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Output handshake pacing
  initial forever begin
    @(posedge clk); #1;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compare presented output against oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = q[0];
        if (!seen) begin
          seen = 1;
          chk("latency", 32'(($time - e.t) / 10), 32'(e.lat));
        end
        chk("result", 32'(result), 32'(e.r));
        chk("flags_cznv", {flag_c, flag_z, flag_n, flag_v},
            {e.c, e.z, e.n, e.v});
        chk("illegal", 32'(illegal), 32'(e.ill));
        chk("in_ready_done", 32'(in_ready), 32'(out_ready));
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end else if (q.size() > 0 && q[0].t < $time) begin
      chk("in_ready_shift", 32'(in_ready), 0);
    end
  end

  task automatic issue(logic [7:0] a, logic [7:0] b, logic [3:0] op);
    exp_t e;
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    in_valid = 1; op_a = a; op_b = b; op_sel = op;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(a, b, op);
        e.t = $time;
        q.push_back(e);
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 0;
    op_a = 8'hAA; op_b = 8'h55; op_sel = 4'd1;
  endtask

  initial begin
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", {flag_c, flag_z, flag_n, flag_v, illegal}, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 1);

    issue(8'd2, 8'd5, 4'd1);
    issue(8'd100, 8'd50, 4'd1);
    issue(8'd3, 8'd5, 4'd2);
    issue(8'd9, 8'd9, 4'd2);
    issue(8'h81, 8'd3, 4'd9);
    issue(8'h90, 8'd4, 4'd11);
    issue(8'hC3, 8'd0, 4'd10);
    idle();

    bp_mode = 2;
    repeat (2) @(posedge clk);
    issue(8'd100, 8'd100, 4'd1);
    idle();
    repeat (3) @(posedge clk);
    #2; bp_mode = 0;
    issue(8'hF0, 8'h0F, 4'd5);
    idle();
    repeat (3) @(posedge clk);

    for (int i = 0; i < 4; i++)
      issue(8'(i * 40 + 7), 8'(i * 70 + 3), 4'd1);
    idle();
    repeat (3) @(posedge clk);

    issue(8'h5A, 8'd6, 4'd9);
    idle();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1;
    q.delete();
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 0);
    chk("rst_mid_result", 32'(result), 0);
    chk("rst_mid_flags", {flag_c, flag_z, flag_n, flag_v, illegal}, 0);
    @(posedge clk); #1; rst = 0;
    repeat (10) @(posedge clk);
    issue(8'h12, 8'h34, 4'd13);
    idle();

    bp_mode = 1;
    for (int i = 0; i < 200; i++) begin
      issue(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    bp_mode = 0;

    for (int k = 0; k < 2000 && q.size() > 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain_queue_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered, multi-cycle successor to the combinational 8-bit ALU.
- Keeps opcodes 0–8 and adds barrel-free iterative variable shifts, status flags and a valid/ready handshake on both input and output.
- Sits between an operand/issue source and a result consumer. Variable shifts are done one bit per clock, so no barrel shifter is needed.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), width of the shift-amount field (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B; ops 9–11 use op_b[SHW-1:0] as the shift amount n.
- op_sel  input  4  opcode.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes the result; transfer when out_valid && out_ready at a rising edge.
- result  output  WIDTH  registered result.
- flag_c  output  1  carry/borrow/last bit shifted out.
- flag_z  output  1  result == 0.
- flag_n  output  1  result[WIDTH-1].
- flag_v  output  1  signed overflow.
- illegal  output  1  opcode 12–15 was issued.

Behaviour:
- Opcodes:
  - 0 NOP → 0.
  - 1 ADD: a+b.
  - 2 SUB: a−b.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 NOT: ~a.
  - 7 SHL1: a<<1.
  - 8 SHR1: a>>1 (logical).
  - 9 SHL by n.
  - 10 SHR by n (logical).
  - 11 SRA by n (arithmetic, MSB replicated).
  - 12–15: result 0, illegal=1.
- All arithmetic is modulo 2^WIDTH.
- Flags:
  - flag_c:
    - ADD: carry out of bit WIDTH-1.
    - SUB: borrow (1 iff a<b unsigned).
    - Ops 7–11: last bit shifted out; 0 if n=0.
    - All other ops: 0.
  - flag_v:
    - ADD: operand signs equal and result sign differs.
    - SUB: operand signs differ and result sign differs from a.
    - All other ops: 0.
  - flag_z and flag_n are computed from the final result for every op, including illegal opcodes.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = !rst && (state==IDLE || (state==DONE && out_ready)).
  - On accept:
    - If the op is not 9–11, or n==0: compute, register result/flags, go to DONE. out_valid rises the cycle after accept (latency 1).
    - Otherwise: load shift register = op_a, count = n, latch op, go to SHIFT.
  - SHIFT: each edge shifts one bit, records the bit shifted out and decrements count. When count==1 at that edge, go to DONE. out_valid rises n+1 cycles after accept.
  - DONE: out_valid=1. result, flags and illegal are held stable while out_ready=0.
    - out_ready=1 with no new accept → IDLE.
    - Out transfer and a new accept on the same edge → behave as accept from IDLE. This gives back-to-back throughput of 1 op/cycle for latency-1 ops.
- Inputs are sampled only at the accept edge. Changes to op_a, op_b or op_sel afterwards have no effect on the op in flight.
- in_ready=0 during SHIFT; no new op is accepted mid-shift.
- Reset (any state, including mid-SHIFT):
  - Next state IDLE; the in-flight op is discarded with no output.
  - out_valid=0, result=0, all flags=0, illegal=0, count=0.
  - in_ready is low while rst is high.

Test Plan:
- WIDTH=8, ADD a=2, b=5 → one cycle after accept: out_valid=1, result=7, c=0, z=0, n=0, v=0. ADD a=100, b=50 → result=150 (0x96), v=1, n=1, c=0.
- SUB a=3, b=5 → result=254 (0xFE), c=1, n=1, v=0. SUB a=9, b=9 → result=0, z=1, c=0.
- SHL a=0x81, n=3 → out_valid exactly 4 cycles after accept, result=0x08, c=0, in_ready=0 throughout SHIFT. SRA a=0x90, n=4 → result=0xF9, latency 5, n=1.
- Back-pressure: ADD accepted, out_ready held 0 for 3 cycles → result and flags constant, in_ready=0. Then out_ready=1 together with in_valid=1 (XOR 0xF0^0x0F) → both transfers on the same edge, next result=0xFF, out_valid stays high.
- Stream of 4 ADDs with out_ready=1 permanently → one result per cycle, no bubbles, values in issue order.
- rst asserted 2 cycles into SHL n=6 → next cycle out_valid=0, result=0, flags=0, no output ever produced for that op. Opcode 13 issued after reset → result=0, illegal=1, z=1.
